// File: rtl/alu_acc_seq.sv
// Command sequencer in front of a 4-bit combinational ALU: keeps an accumulator, runs ALU ops,
// LOAD/READ, and a 4-pass shift-add MUL, and returns results over a valid/ready response port.
module alu_acc_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_cf,
    input  logic       alu_of,
    input  logic       alu_zf,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_cf,
    output logic       rsp_of,
    output logic       rsp_zf,
    output logic       rsp_err,
    output logic [3:0] acc
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t     state, state_nxt;
    logic [2:0] sel_q;
    logic [3:0] data_q;
    logic [3:0] p, md, m;
    logic [1:0] cnt;
    logic       lost, of_sticky;
    logic       accept;
    logic [3:0] p_nxt;
    logic       of_nxt;
    logic [3:0] exec_res;
    logic       exec_arith;

    assign accept     = cmd_valid && cmd_ready;
    assign p_nxt      = m[0] ? alu_out : p;
    assign of_nxt     = of_sticky | (m[0] & (alu_cf | lost));
    // Compare selects yield a boolean; only bit 0 of the ALU result is meaningful.
    assign exec_res   = (sel_q[2:1] == 2'b11) ? {3'b000, alu_out[0]} : alu_out;
    assign exec_arith = (sel_q[2:1] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (!cmd_op[3])          state_nxt = EXEC;
                else if (cmd_op == 4'd9) state_nxt = MUL;
                else                     state_nxt = RESP;
            end
            EXEC:    state_nxt = RESP;
            MUL:     if (cnt == 2'd3) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
        alu_a     = acc;
        alu_b     = 4'd0;
        alu_sel   = 3'b000;
        case (state)
            EXEC: begin
                alu_b   = data_q;
                alu_sel = sel_q;
            end
            MUL: begin
                alu_a = p;
                alu_b = md;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 4'd0;
            sel_q     <= 3'd0;
            data_q    <= 4'd0;
            p         <= 4'd0;
            md        <= 4'd0;
            m         <= 4'd0;
            cnt       <= 2'd0;
            lost      <= 1'b0;
            of_sticky <= 1'b0;
            rsp_data  <= 4'd0;
            rsp_cf    <= 1'b0;
            rsp_of    <= 1'b0;
            rsp_zf    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sel_q     <= cmd_op[2:0];
                    data_q    <= cmd_data;
                    p         <= 4'd0;
                    md        <= acc;
                    m         <= cmd_data;
                    cnt       <= 2'd0;
                    lost      <= 1'b0;
                    of_sticky <= 1'b0;
                    rsp_cf    <= 1'b0;
                    rsp_of    <= 1'b0;
                    rsp_zf    <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (cmd_op == 4'd8) begin
                        acc      <= cmd_data;
                        rsp_data <= cmd_data;
                        rsp_zf   <= (cmd_data == 4'd0);
                    end else if (cmd_op == 4'd10) begin
                        rsp_data <= acc;
                        rsp_zf   <= (acc == 4'd0);
                    end else if (cmd_op > 4'd10) begin
                        rsp_data <= acc;
                        rsp_err  <= 1'b1;
                    end
                end
                EXEC: begin
                    acc      <= exec_res;
                    rsp_data <= exec_res;
                    rsp_zf   <= alu_zf;
                    rsp_cf   <= exec_arith & alu_cf;
                    rsp_of   <= exec_arith & alu_of;
                end
                MUL: begin
                    // A carry out of any accepted partial sum, or a set bit shifted out of the
                    // multiplicand before it is added, both mean the product exceeds 4 bits.
                    p         <= p_nxt;
                    of_sticky <= of_nxt;
                    lost      <= lost | md[3];
                    md        <= {md[2:0], 1'b0};
                    m         <= {1'b0, m[3:1]};
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        acc      <= p_nxt;
                        rsp_data <= p_nxt;
                        rsp_cf   <= 1'b0;
                        rsp_of   <= of_nxt;
                        rsp_zf   <= (p_nxt == 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: behavioural ALU on the operand bus, integer reference model of every command.
module tb_alu_acc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op, cmd_data;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_cf, alu_of, alu_zf;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_cf, rsp_of, rsp_zf, rsp_err;
    logic [3:0] acc;
    logic [4:0] alu_sum;

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;

    alu_acc_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_cf(alu_cf), .alu_of(alu_of), .alu_zf(alu_zf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cf(rsp_cf), .rsp_of(rsp_of), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .acc(acc)
    );

    always #5 clk = ~clk;

    // Combinational ALU; flags for logic/compare selects are deliberately junk.
    always_comb begin
        alu_sum = 5'd0;
        alu_out = 4'd0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = alu_sum[3:0];
                alu_cf  = alu_sum[4];
                alu_of  = (alu_a[3] == alu_b[3]) && (alu_out[3] != alu_a[3]);
            end
            3'd1: begin
                alu_out = alu_a - alu_b;
                alu_cf  = (alu_a < alu_b);
                alu_of  = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_a[3]);
            end
            3'd2: alu_out = alu_a | alu_b;
            3'd3: alu_out = alu_a & alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: alu_out = {3'b000, alu_a < alu_b};
            default: alu_out = {3'b000, alu_a == alu_b};
        endcase
        if (alu_sel >= 3'd2) begin
            alu_cf = ^alu_a | alu_b[0];
            alu_of = ^alu_b | alu_a[0];
        end
        alu_zf = (alu_out == 4'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 7) ? v - 16 : v;
    endfunction

    function automatic void ref_cmd(input int op, input int d, input int a,
                                    output int res, output int cf, output int of,
                                    output int zf, output int err, output int lat);
        int t;
        res = a; cf = 0; of = 0; err = 0; lat = 2;
        case (op)
            0: begin t = a + d; res = t % 16; cf = int'(t > 15);
                     t = sgn(a) + sgn(d); of = int'(t > 7 || t < -8); end
            1: begin t = a - d; res = (t + 16) % 16; cf = int'(a < d);
                     t = sgn(a) - sgn(d); of = int'(t > 7 || t < -8); end
            2: res = a | d;
            3: res = a & d;
            4: res = a ^ d;
            5: res = 15 - a;
            6: res = int'(a < d);
            7: res = int'(a == d);
            8: begin res = d; lat = 1; end
            9: begin t = a * d; res = t % 16; of = int'(t > 15); lat = 5; end
            10: lat = 1;
            default: begin err = 1; lat = 1; end
        endcase
        zf = (err != 0) ? 0 : int'(res == 0);
    endfunction

    task automatic do_cmd(input int op, input int d, input int hold);
        int res, cf, of, zf, err, lat, n;
        logic [3:0] held;
        ref_cmd(op, d, acc_m, res, cf, of, zf, err, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op[3:0];
        cmd_data  = d[3:0];
        rsp_ready = (hold == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("latency op%0d", op), n, lat);
        check($sformatf("rsp_data op%0d", op), rsp_data, res);
        check($sformatf("rsp_cf op%0d", op), rsp_cf, cf);
        check($sformatf("rsp_of op%0d", op), rsp_of, of);
        check($sformatf("rsp_zf op%0d", op), rsp_zf, zf);
        check($sformatf("rsp_err op%0d", op), rsp_err, err);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'd8;
            cmd_data  = ~held;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, held);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("retired", rsp_valid, 0);
        check("acc_after", acc, res);
        check("idle_ready", cmd_ready, 1);
        acc_m = res;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 4'd0;
        cmd_data = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_acc", acc, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_flags", {rsp_data, rsp_cf, rsp_of, rsp_zf, rsp_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);

        // Reset during the second MUL iteration
        do_cmd(8, 5, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd9; cmd_data = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midmul_acc", acc, 0);
        check("midmul_ready", cmd_ready, 0);
        check("midmul_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        acc_m = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midmul_no_rsp", rsp_valid, 0);
            check("midmul_ready_after", cmd_ready, 1);
        end

        do_cmd(8, 9, 0);  do_cmd(0, 9, 0);  do_cmd(1, 2, 0);
        do_cmd(8, 12, 0); do_cmd(3, 10, 0); do_cmd(7, 8, 0);  do_cmd(6, 0, 0);
        do_cmd(8, 5, 0);  do_cmd(9, 3, 0);
        do_cmd(8, 5, 0);  do_cmd(9, 4, 0);
        do_cmd(8, 7, 0);  do_cmd(9, 0, 0);
        do_cmd(8, 3, 0);  do_cmd(10, 0, 5);
        do_cmd(8, 6, 0);  do_cmd(12, 1, 0); do_cmd(10, 0, 0);
        do_cmd(8, 15, 0); do_cmd(9, 15, 0); do_cmd(1, 3, 2);

        for (int k = 0; k < 80; k++) begin
            int op, d, h;
            op = int'($urandom_range(0, 15));
            d  = int'($urandom_range(0, 15));
            h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 4) == 0) op = 9;
            do_cmd(op, d, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Sequencing stage directly upstream of the 4-bit ALU. Accepts commands over a valid/ready handshake and drives the ALU operands and select from a 4-bit accumulator plus the command operand.
- Captures the ALU result and flags back into the accumulator, and returns a response over a second valid/ready handshake.
- Adds a multi-cycle unsigned MUL built from repeated ALU add passes.

Parameters:
- None. Data width is fixed at 4 to match the ALU.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_op  in  4  0-7 = ALU sel passthrough; 8 LOAD; 9 MUL; 10 READ; 11-15 illegal
cmd_data  in  4  command operand
alu_a  out  4  ALU operand a
alu_b  out  4  ALU operand b
alu_sel  out  3  ALU function select
alu_out  in  4  ALU result
alu_cf  in  1  ALU carry flag
alu_of  in  1  ALU overflow flag
alu_zf  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  4  accumulator value after the command
rsp_cf  out  1  carry flag of the command
rsp_of  out  1  overflow flag of the command
rsp_zf  out  1  zero flag of the command
rsp_err  out  1  illegal opcode
acc  out  4  current accumulator register

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset values: state IDLE; acc=0; all rsp_* outputs=0; cmd_ready=0 while rst is high.
- Reset mid-operation: reset aborts the command in flight. It is not replayed and no response is issued.
- States and transitions:
  - IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/data.
    - ops 0-7 go to EXEC.
    - op 9 goes to MUL.
    - ops 8, 10 and 11-15 go to RESP.
  - EXEC (1 cycle): drive alu_a=acc, alu_b=data, alu_sel=op[2:0]. At the clock edge:
    - acc<=alu_out; rsp_zf<=alu_zf.
    - rsp_cf/rsp_of<=alu_cf/alu_of only for sel 000/001; otherwise 0. The ALU flags are not meaningful for sel>=010.
    - Compare ops (110, 111) store 1/0 into acc.
    - Next state RESP.
  - MUL (exactly 4 cycles, iteration counter 0..3): uses registers p (init 0), md (init acc), m (init data), and a sticky lost flag (init 0). Each cycle:
    - Drive alu_a=p, alu_b=md, alu_sel=000.
    - If m[0]: p<=alu_out; of_sticky|=alu_cf|lost.
    - Then lost|=md[3]; md<=md<<1; m<=m>>1.
    - After iteration 3: acc<=p; rsp_cf=0; rsp_of=of_sticky (1 iff true unsigned product >15); rsp_zf=(p==0). Next state RESP.
  - RESP: rsp_valid=1; rsp_data=acc. rsp_data and the flags stay stable until rsp_ready is seen. When rsp_valid&rsp_ready, next state IDLE.
- Command results:
  - LOAD: acc<=data; zf=(data==0); cf=of=0.
  - READ: acc unchanged; zf=(acc==0); cf=of=0.
  - Illegal ops: acc unchanged; rsp_err=1; flags 0. rsp_err is 0 for all legal ops.
- Latency, with the command accepted at edge N:
  - LOAD/READ/illegal: rsp_valid from N+1.
  - ALU ops: rsp_valid from N+2.
  - MUL: rsp_valid from N+5.
- cmd_ready is deasserted in every non-IDLE state, so no command is accepted in the same cycle a response retires. Minimum spacing between command acceptances is 2 cycles (LOAD) or 3 cycles (ALU op).
- ALU drive outside EXEC/MUL: alu_a=acc, alu_b=0, alu_sel=000. The ALU is combinational, and its outputs are sampled only in EXEC/MUL.
- Arithmetic: all results are truncated to 4 bits. Add wraps modulo 16.

Test Plan:
- Reset mid-MUL: LOAD 5, issue MUL 3, assert rst on the 2nd MUL cycle -> acc=0, rsp_valid never asserts, cmd_ready=1 after rst falls.
- Add and sub: LOAD 9, ADD (op 0) data 9 -> rsp_data=2, cf=1, of=1, zf=0 at N+2. Then SUB (op 1) data 2 -> rsp_data=0, zf=1.
- Logic and compare: LOAD 0xC, AND (op 3) data 0xA -> 8, cf=of=0. Then EQ (op 7) data 8 -> acc=1. Then LT (op 6) data 0 -> acc=0, zf=1.
- Multiply: LOAD 5, MUL 3 -> rsp_data=15, of=0 at N+5. LOAD 5, MUL 4 -> rsp_data=4, of=1. LOAD 7, MUL 0 -> 0, zf=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and rsp_data stay stable, cmd_ready=0, a second cmd_valid is not accepted until one cycle after rsp_ready=1.
- Illegal op: cmd_op=12 with acc=6 -> rsp_err=1, rsp_data=6, flags 0, acc still 6 afterward.
